dcache_dm: RTL and testbench
============================

Name: dcache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the memory-stage load/store path and the byte-addressed data memory.
- Presents the same access semantics as the data memory: word or unsigned-byte read, word or byte store, `addr_mode` 0 = word, 1 = byte.
- Read hits return data combinationally. A read miss stalls the pipeline one cycle while a word line is fetched.
- Provides saturating hit/miss counters for performance analysis.

Parameters:
- DATA_WIDTH, 32, address and data width.
- BYTE_WIDTH, 8, byte width.
- SETS, 64, number of one-word lines; power of two, ≥2.
- INDEX_BITS, $clog2(SETS), index width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_a  in  DATA_WIDTH  access byte address.
- cpu_wd  in  DATA_WIDTH  store data.
- cpu_addr_mode  in  1  0 word, 1 byte.
- cpu_we  in  1  store request.
- cpu_re  in  1  load request.
- cpu_rd  out  DATA_WIDTH  load data; unsigned byte is zero-extended.
- stall  out  1  CPU must hold all cpu_* inputs stable while high.
- mem_a  out  DATA_WIDTH  data-memory address.
- mem_wd  out  DATA_WIDTH  data-memory write data.
- mem_addr_mode  out  1  data-memory addressing mode.
- mem_we  out  1  data-memory write enable.
- mem_rd  in  DATA_WIDTH  data-memory read data; combinational, same cycle.
- hit_count  out  32  cached read hits.
- miss_count  out  32  read misses, including uncached reads.

Behaviour:
- Address split:
  - index = cpu_a[INDEX_BITS+1:2]
  - tag = cpu_a[DATA_WIDTH-1:INDEX_BITS+2]
  - offset = cpu_a[1:0]
- Per line: valid bit, tag, DATA_WIDTH data word.
- Uncached access = word mode with offset != 0. It always misses, never allocates, and never updates a line.
- FSM states: IDLE, FILL.
  - IDLE → FILL when cpu_re && !cpu_we && (tag miss || invalid line || uncached). Latch cpu_a, cpu_addr_mode and an uncached flag.
  - FILL → IDLE unconditionally after one cycle.
- Reset (asynchronous, any state):
  - state = IDLE; all valid bits = 0.
  - hit_count = miss_count = 0.
  - stall = 0; mem_we = 0.
  - Other outputs follow the IDLE combinational mapping with inputs.
- IDLE memory-side mapping:
  - mem_a = cpu_a, mem_wd = cpu_wd, mem_addr_mode = cpu_addr_mode.
  - mem_we = cpu_we.
- Read hit in IDLE:
  - stall = 0.
  - cpu_rd = line word for word mode; zero-extended byte[offset] for byte mode.
  - hit_count +1 on the edge.
- Read miss in IDLE:
  - stall = 1; cpu_rd = 0.
  - miss_count +1 on the edge.
- FILL memory-side mapping:
  - mem_we = 0.
  - Cached fill: mem_a = {latched_a[31:2], 2'b00}, mem_addr_mode = 0.
  - Uncached: mem_a = latched_a, mem_addr_mode = 0.
- FILL cycle:
  - stall = 0.
  - cpu_rd is derived from mem_rd using the latched mode and offset; uncached returns raw mem_rd.
  - On the edge, a cached fill writes the line: valid = 1, tag updated.
  - A fill replaces any resident line; write-through means there is no dirty eviction.
- Store (cpu_we in IDLE):
  - Written through to memory the same cycle; stall = 0; counters unchanged.
  - Store hit, byte mode: updates byte[offset] of the line.
  - Store hit, aligned word: updates the whole line.
  - Store hit, uncached word: invalidates the line.
  - Store miss: no allocation.
- cpu_we and cpu_re both high: treated as a store; the read is ignored.
- cpu_we is ignored in FILL; the CPU is held by stall.
- Counters saturate at 32'hFFFF_FFFF.
- Latency: read hit 0 cycles; read miss 1 stall cycle; store 0 cycles.

Decomposition:
- Shared package dcache_pkg:
  - cache_state_t enum {IDLE, FILL}.
  - ADDR_MODE_WORD = 1'b0, ADDR_MODE_BYTE = 1'b1.
  - Byte-extract function (word, offset, mode) → zero-extended read data, shared with the memory stage.
- One natural sub-module, dcache_tag_array: valid/tag/data storage with read port, line-fill port, byte-write port and async clear.

Test Plan:
- Read miss then hit: rst_n pulse, memory holds 0x00010000 = 32'hDEADBEEF. Word read of 0x00010000:
  - cycle 0: stall = 1.
  - cycle 1: cpu_rd = DEADBEEF, stall = 0.
  - cycle 2: repeat read hits, stall = 0, hit_count = 1, miss_count = 1.
- Byte read hit: after the above, byte read of 0x00010002 → cpu_rd = 32'h000000AD, stall = 0, no mem fetch.
- Byte store hit: byte store 0x5A to 0x00010001 → mem_we = 1, mem_a = 0x00010001. Next word read → 32'hDEAD5AEF with no stall.
- Conflict eviction: SETS = 64; read 0x00010000, then read 0x00010100 (same index, different tag) → miss with line replaced. Reread 0x00010000 → miss again; miss_count = 3.
- Uncached access: word read of 0x00010003 → stall one cycle, mem_a = 0x00010003 with addr_mode 0, raw mem_rd returned. Reread → miss again (no allocation).
- Reset mid-FILL: drop rst_n during FILL → stall = 0, state IDLE, counters 0. The read of a previously filled address misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, constants and read-data formatting for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned OFFSET_BITS = 2;

    localparam logic ADDR_MODE_WORD = 1'b0;
    localparam logic ADDR_MODE_BYTE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } cache_state_t;

    // Outstanding read miss: original address, access mode and uncached flag
    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic              mode;
        logic              uncached;
    } fill_req_t;

    // Format a word for the load path: whole word, or zero-extended byte[offset]
    function automatic logic [WORD_W-1:0] extract_rd(
        input logic [WORD_W-1:0]      word,
        input logic [OFFSET_BITS-1:0] offset,
        input logic                   mode
    );
        logic [BYTE_W-1:0] b;
        b = word[int'(offset)*BYTE_W +: BYTE_W];
        if (mode == ADDR_MODE_BYTE) begin
            extract_rd = WORD_W'(b);
        end else begin
            extract_rd = word;
        end
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid/tag/data storage for a direct-mapped cache of one-word lines.
module dcache_tag_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned SETS       = 64,
    localparam int unsigned INDEX_BITS = $clog2(SETS),
    localparam int unsigned TAG_BITS   = DATA_WIDTH - INDEX_BITS - 2,
    localparam int unsigned BYTES      = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // read port
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    // line-fill port
    input  logic                  fill_en,
    input  logic [INDEX_BITS-1:0] fill_index,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic [DATA_WIDTH-1:0] fill_data,
    // byte-write port
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [BYTES-1:0]      wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    // line invalidate
    input  logic                  inv_en,
    input  logic [INDEX_BITS-1:0] inv_index
);

    logic [SETS-1:0]       valid_q;
    logic [TAG_BITS-1:0]   tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS];

    // Valid bits: cleared asynchronously, set by fills, cleared by invalidates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (fill_en) begin
                valid_q[fill_index] <= 1'b1;
            end
            if (inv_en) begin
                valid_q[inv_index] <= 1'b0;
            end
        end
    end

    // Tag and data storage; contents are don't-care until the valid bit is set
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= fill_data;
        end else if (wr_en) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (wr_be[b]) begin
                    data_mem[wr_index][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with hit/miss counters.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned SETS       = 64,
    localparam int unsigned INDEX_BITS = $clog2(SETS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] cpu_a,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    input  logic                  cpu_addr_mode,
    input  logic                  cpu_we,
    input  logic                  cpu_re,
    output logic [DATA_WIDTH-1:0] cpu_rd,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_addr_mode,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int unsigned TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;
    localparam int unsigned BYTES    = DATA_WIDTH / BYTE_WIDTH;

    cache_state_t state_q, state_d;
    fill_req_t    req_q, req_d;

    logic [INDEX_BITS-1:0] cpu_index;
    logic [TAG_BITS-1:0]   cpu_tag;
    logic [1:0]            cpu_offset;
    logic                  uncached_c;
    logic                  line_hit_c;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  fill_en;
    logic                  wr_en;
    logic [BYTES-1:0]      wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  inv_en;
    logic                  hit_inc;
    logic                  miss_inc;

    // Address split and hit detection for the access presented this cycle
    assign cpu_index  = cpu_a[INDEX_BITS+1:2];
    assign cpu_tag    = cpu_a[DATA_WIDTH-1:INDEX_BITS+2];
    assign cpu_offset = cpu_a[1:0];
    assign uncached_c = (cpu_addr_mode == ADDR_MODE_WORD) && (cpu_offset != 2'b00);
    assign line_hit_c = rd_valid && (rd_tag == cpu_tag);

    dcache_tag_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .SETS       (SETS)
    ) u_tag_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_index   (cpu_index),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .fill_en    (fill_en),
        .fill_index (req_q.a[INDEX_BITS+1:2]),
        .fill_tag   (req_q.a[DATA_WIDTH-1:INDEX_BITS+2]),
        .fill_data  (mem_rd),
        .wr_en      (wr_en),
        .wr_index   (cpu_index),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .inv_en     (inv_en),
        .inv_index  (cpu_index)
    );

    // State, pending-miss and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            if (hit_inc && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_inc && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

    // Next state, memory-side mapping, load data and array updates
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        cpu_rd        = '0;
        stall         = 1'b0;
        mem_a         = cpu_a;
        mem_wd        = cpu_wd;
        mem_addr_mode = cpu_addr_mode;
        mem_we        = 1'b0;
        fill_en       = 1'b0;
        wr_en         = 1'b0;
        wr_be         = '0;
        wr_data       = cpu_wd;
        inv_en        = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                mem_we = cpu_we;
                if (cpu_we) begin
                    // write-through store; only a resident line is touched
                    if (line_hit_c) begin
                        if (cpu_addr_mode == ADDR_MODE_BYTE) begin
                            wr_en   = 1'b1;
                            wr_be   = BYTES'(1) << cpu_offset;
                            wr_data = {BYTES{cpu_wd[BYTE_WIDTH-1:0]}};
                        end else if (uncached_c) begin
                            inv_en = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            wr_be = '1;
                        end
                    end
                end else if (cpu_re) begin
                    if (line_hit_c && !uncached_c) begin
                        cpu_rd  = extract_rd(rd_data, cpu_offset, cpu_addr_mode);
                        hit_inc = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = FILL;
                        req_d    = '{a: cpu_a, mode: cpu_addr_mode, uncached: uncached_c};
                    end
                end
            end
            FILL: begin
                mem_addr_mode = ADDR_MODE_WORD;
                state_d       = IDLE;
                if (req_q.uncached) begin
                    mem_a  = req_q.a;
                    cpu_rd = mem_rd;
                end else begin
                    mem_a   = {req_q.a[DATA_WIDTH-1:2], 2'b00};
                    cpu_rd  = extract_rd(mem_rd, req_q.a[1:0], req_q.mode);
                    fill_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is asserted the CPU is never stalled and memory is never written
        if (!rst_n) begin
            stall    = 1'b0;
            mem_we   = 1'b0;
            wr_en    = 1'b0;
            hit_inc  = 1'b0;
            miss_inc = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Randomized scoreboard bench for dcache_dm with a transaction-level cache model.
module tb_dcache_dm;

    localparam logic [31:0] BASE      = 32'h0001_0000;
    localparam int          MEM_BYTES = 1040;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_a, cpu_wd, cpu_rd;
    logic        cpu_addr_mode, cpu_we, cpu_re, stall;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_addr_mode, mem_we;
    logic [31:0] hit_count, miss_count;

    always #5 clk = ~clk;

    dcache_dm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_a         (cpu_a),
        .cpu_wd        (cpu_wd),
        .cpu_addr_mode (cpu_addr_mode),
        .cpu_we        (cpu_we),
        .cpu_re        (cpu_re),
        .cpu_rd        (cpu_rd),
        .stall         (stall),
        .mem_a         (mem_a),
        .mem_wd        (mem_wd),
        .mem_addr_mode (mem_addr_mode),
        .mem_we        (mem_we),
        .mem_rd        (mem_rd),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    // Byte-addressed little-endian data memory over a small window
    logic [7:0] mem_arr [MEM_BYTES];
    bit         tb_init;
    int         wo;

    always_comb begin
        int o;
        o      = int'(mem_a - BASE);
        mem_rd = 32'h0;
        if (mem_a >= BASE && o <= MEM_BYTES - 4) begin
            if (mem_addr_mode) mem_rd = {24'h0, mem_arr[o]};
            else               mem_rd = {mem_arr[o+3], mem_arr[o+2], mem_arr[o+1], mem_arr[o]};
        end
    end

    always @(posedge clk) begin
        if (!tb_init) begin
            for (int i = 0; i < MEM_BYTES; i++) mem_arr[i] <= 8'(i * 37 + 11) ^ 8'(i >> 3);
        end else if (mem_we) begin
            wo = int'(mem_a - BASE);
            if (mem_a >= BASE && wo <= MEM_BYTES - 4) begin
                if (mem_addr_mode) begin
                    mem_arr[wo] <= mem_wd[7:0];
                end else begin
                    mem_arr[wo]   <= mem_wd[7:0];
                    mem_arr[wo+1] <= mem_wd[15:8];
                    mem_arr[wo+2] <= mem_wd[23:16];
                    mem_arr[wo+3] <= mem_wd[31:24];
                end
            end
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int o;
        o = int'(a - BASE);
        return {mem_arr[o+3], mem_arr[o+2], mem_arr[o+1], mem_arr[o]};
    endfunction

    // Cache model: which aligned word each set holds, and its contents
    bit          res_v  [64];
    logic [31:0] res_wa [64];
    logic [31:0] res_d  [64];
    int unsigned exp_hits, exp_misses;

    typedef struct {
        bit          is_store;
        bit          miss;
        logic [31:0] rd;
        logic [31:0] fetch_a;
        logic [31:0] st_a;
        bit          st_mode;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    bit   saw_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) res_v[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Monitor: pops an expectation whenever a load completes or a store is presented
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (saw_stall) begin
                if (q.size() == 0) check("fill_without_expect", 32'd1, 32'd0);
                else begin
                    check("fill_mem_we", 32'(mem_we), 32'd0);
                    check("fill_mem_a", mem_a, q[0].fetch_a);
                    check("fill_mem_mode", 32'(mem_addr_mode), 32'd0);
                end
            end
            if (cpu_we) begin
                if (q.size() == 0) check("store_without_expect", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("store_kind", 32'(e.is_store), 32'd1);
                    check("store_mem_we", 32'(mem_we), 32'd1);
                    check("store_mem_a", mem_a, e.st_a);
                    check("store_mem_mode", 32'(mem_addr_mode), 32'(e.st_mode));
                    check("store_stall", 32'(stall), 32'd0);
                end
                saw_stall <= 1'b0;
            end else if (cpu_re) begin
                if (stall) begin
                    saw_stall <= 1'b1;
                end else if (q.size() == 0) begin
                    check("load_without_expect", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("load_rd", cpu_rd, e.rd);
                    check("load_missed", 32'(saw_stall), 32'(e.miss));
                    saw_stall <= 1'b0;
                end
            end
        end
    end

    // Issue one access, update the model, and hold inputs while stalled
    task automatic access(input bit we, input bit re, input logic [31:0] a, input logic [31:0] wd,
                          input bit mode, input bit force_e, input logic [31:0] f_rd, input bit f_miss);
        exp_t        e;
        int          idx, n;
        logic [31:0] wa, w;
        bit          unc, hit;
        idx = int'(a[7:2]);
        wa  = {a[31:2], 2'b00};
        unc = !mode && (a[1:0] != 2'b00);
        hit = res_v[idx] && (res_wa[idx] == wa);
        e.is_store = we; e.miss = 1'b0; e.rd = 32'h0; e.fetch_a = 32'h0;
        e.st_a = a; e.st_mode = mode;
        if (we) begin
            if (hit) begin
                if (mode)     res_d[idx][int'(a[1:0])*8 +: 8] = wd[7:0];
                else if (unc) res_v[idx] = 1'b0;
                else          res_d[idx] = wd;
            end
            q.push_back(e);
        end else if (re) begin
            if (hit && !unc) begin
                exp_hits++;
                e.rd = mode ? {24'h0, res_d[idx][int'(a[1:0])*8 +: 8]} : res_d[idx];
            end else begin
                exp_misses++;
                e.miss    = 1'b1;
                e.fetch_a = unc ? a : wa;
                w         = mem_word(e.fetch_a);
                e.rd      = unc ? w : (mode ? {24'h0, w[int'(a[1:0])*8 +: 8]} : w);
                if (!unc) begin
                    res_v[idx]  = 1'b1;
                    res_wa[idx] = wa;
                    res_d[idx]  = w;
                end
            end
            if (force_e) begin
                e.rd   = f_rd;
                e.miss = f_miss;
            end
            q.push_back(e);
        end
        cpu_we = we; cpu_re = re; cpu_a = a; cpu_wd = wd; cpu_addr_mode = mode;
        n = 0;
        @(negedge clk);
        while (stall) begin
            n++;
            if (n > 3) begin
                check("stall_timeout", 32'd1, 32'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        cpu_we = 1'b0; cpu_re = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        bit          m;
        cpu_a = BASE; cpu_wd = 32'h0; cpu_addr_mode = 1'b0;
        cpu_we = 1'b0; cpu_re = 1'b1; rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 tb_init = 1'b1;

        // Reset state with a pending read (and then a store) on the inputs
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        cpu_re = 1'b0; cpu_we = 1'b1;
        #1 check("rst_mem_we", 32'(mem_we), 32'd0);
        cpu_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Preload through a store miss, then miss followed by hit
        access(1, 0, BASE, 32'hDEADBEEF, 0, 0, 0, 0);
        access(0, 1, BASE, 0, 0, 1, 32'hDEADBEEF, 1);
        access(0, 1, BASE, 0, 0, 1, 32'hDEADBEEF, 0);
        check("dir_hit_count_1", hit_count, 32'd1);
        check("dir_miss_count_1", miss_count, 32'd1);

        // Byte read hit, byte store hit, word read of the updated line
        access(0, 1, BASE + 32'd2, 0, 1, 1, 32'h0000_00AD, 0);
        access(1, 0, BASE + 32'd1, 32'h0000_005A, 1, 0, 0, 0);
        access(0, 1, BASE, 0, 0, 1, 32'hDEAD5AEF, 0);

        // Conflict eviction on set 0
        access(0, 1, BASE + 32'h100, 0, 0, 0, 0, 0);
        access(0, 1, BASE, 0, 0, 1, 32'hDEAD5AEF, 1);
        check("dir_miss_count_3", miss_count, 32'd3);
        check("dir_hit_count_3", hit_count, 32'd3);

        // Uncached word read: raw misaligned word, never allocates
        access(0, 1, BASE + 32'd3, 0, 0, 0, 0, 0);
        access(0, 1, BASE + 32'd3, 0, 0, 0, 0, 0);
        check("dir_miss_count_5", miss_count, 32'd5);

        // Reset asserted during a fill cycle
        mon_en = 1'b0;
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_a = BASE + 32'h200; cpu_addr_mode = 1'b0;
        @(negedge clk);
        check("midfill_stall_before", 32'(stall), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midfill_stall", 32'(stall), 32'd0);
        check("midfill_hit_count", hit_count, 32'd0);
        check("midfill_miss_count", miss_count, 32'd0);
        cpu_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1 mon_en = 1'b1;
        access(0, 1, BASE, 0, 0, 1, 32'hDEAD5AEF, 1);
        check("post_rst_miss_count", miss_count, 32'd1);
        check("post_rst_hit_count", hit_count, 32'd0);

        // Randomized mix of loads, stores and idle cycles
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            a = BASE + 32'($urandom_range(0, 32'h3FF));
            m = 1'($urandom_range(0, 1));
            if (!m && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            if (r < 45)      access(0, 1, a, 32'h0, m, 0, 0, 0);
            else if (r < 80) access(1, 0, a, $urandom, m, 0, 0, 0);
            else if (r < 90) access(1, 1, a, $urandom, m, 0, 0, 0);
            else             idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        check("final_hit_count", hit_count, 32'(exp_hits));
        check("final_miss_count", miss_count, 32'(exp_misses));
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
